// File: rtl/tomasulo_pkg.sv
// Shared constants and types for the Tomasulo front end.
// Holds the fixed instruction encodings, the fetch FSM state type and a PC step helper.
package tomasulo_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_issue_queue_if.sv
// Instruction-memory fetch port: one strobe per request, single outstanding request.
// master = the fetch unit, slave = the memory.
interface instr_issue_queue_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/instr_fifo.sv
// Small FIFO for fetched instructions; head word is readable combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !clear && !do_pop && (count_q == FULL_COUNT)));

endmodule

// File: rtl/instr_issue_queue.sv
// Fetch stage and issue queue in front of the Tomasulo core: fetches words one request
// at a time, buffers them, presents the head (or NOP) and supports flush/redirect and ecall halt.
module instr_issue_queue
  import tomasulo_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int          CW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  instr_issue_queue_if.master imem,
  input  logic                issue_stall,
  input  logic                flush,
  input  logic [31:0]         flush_pc,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [CW-1:0]       count,
  output logic                halted
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         halted_q;

  logic         fetch_req;
  logic         push;
  logic         pop;
  logic [31:0]  fifo_rdata;
  logic [CW-1:0] fifo_count;

  // Request only with a guaranteed free slot, so the queue can never overflow.
  assign fetch_req   = !reset && (state_q == FETCH) && (fifo_count < FULL_COUNT) && !flush;
  assign imem.req    = fetch_req;
  assign imem.addr   = pc_q;

  assign push        = (state_q == WAIT) && imem.rvalid && !flush;
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && !issue_stall && !flush;

  assign instr       = instr_valid ? fifo_rdata : NOP_INSTR;
  assign count       = fifo_count;
  assign halted      = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (flush) begin
      pc_q     <= flush_pc;
      halted_q <= 1'b0;
      // An in-flight request whose response has not arrived must be drained.
      case (state_q)
        WAIT:    state_q <= imem.rvalid ? FETCH : DRAIN;
        DRAIN:   state_q <= DRAIN;
        default: state_q <= FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_req) state_q <= WAIT;
        end
        WAIT: begin
          if (imem.rvalid) begin
            pc_q <= pc_step(pc_q);
            if (imem.rdata == ECALL_INSTR) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        DRAIN: begin
          if (imem.rvalid) state_q <= FETCH;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata (imem.rdata),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

endmodule
